fetch_pc_unit: RTL and testbench

Parametrised program-counter unit for the instruction-fetch stage. It generates the instruction address each cycle and supports stall, branch and trap redirects with fixed priority, plus a small hardware return-address stack (RAS) for call/return. It drives instruction-memory addressing and reports redirect and RAS events to the pipeline control.

---
 rtl/pc_pkg.sv | 20 ++
 rtl/return_addr_stack.sv | 56 +++++
 rtl/fetch_pc_unit.sv | 102 ++++++++++
 tb/tb_fetch_pc_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch program-counter unit: default widths,
// the address-alignment helper and the next-address cause used for trace.
package pc_pkg;

   localparam int DEFAULT_ADDR_W = 32;

   typedef enum logic [2:0] {
      SEQ,
      HOLD,
      TRAP,
      BRANCH,
      RET
   } pc_cause_e;

   // Clears the low log2(step) bits; step is a power of two.
   function automatic logic [63:0] align_addr(input logic [63:0] addr, input int unsigned step);
      return addr & ~(64'(step) - 64'd1);
   endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: a push when full overwrites the oldest
// entry while the count saturates at the depth.
module return_addr_stack #(
   parameter int ADDR_W    = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             push,
   input  logic                             pop,
   input  logic [ADDR_W-1:0]                push_data,
   output logic [ADDR_W-1:0]                top,
   output logic [$clog2(RAS_DEPTH+1)-1:0]   count,
   output logic                             empty
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   logic [ADDR_W-1:0] mem [RAS_DEPTH];
   logic [PTR_W-1:0]  sp;
   logic [PTR_W-1:0]  sp_next;
   logic [PTR_W-1:0]  sp_prev;

   // sp points at the slot the next push writes; wrap explicitly so a
   // non power-of-two depth still behaves as a ring.
   always_comb begin
      sp_next = (sp == PTR_W'(RAS_DEPTH - 1)) ? '0 : sp + PTR_W'(1);
      sp_prev = (sp == '0) ? PTR_W'(RAS_DEPTH - 1) : sp - PTR_W'(1);
   end

   assign top   = mem[sp_prev];
   assign empty = (count == '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[sp] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sp    <= '0;
         count <= '0;
      end else if (push) begin
         sp <= sp_next;
         if (count != CNT_W'(RAS_DEPTH)) begin
            count <= count + CNT_W'(1);
         end
      end else if (pop && !empty) begin
         sp    <= sp_prev;
         count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch program counter with trap/branch/return redirects,
// stall, and a return-address stack for call/return prediction.
module fetch_pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned       ADDR_W    = DEFAULT_ADDR_W,
   parameter int unsigned       STEP      = 4,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter int unsigned       RAS_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            stall,
   input  logic                            trap_en,
   input  logic [ADDR_W-1:0]               trap_vector,
   input  logic                            branch_en,
   input  logic                            call_en,
   input  logic [ADDR_W-1:0]               branch_target,
   input  logic                            ret_en,
   output logic [ADDR_W-1:0]               ins_address,
   output logic                            ins_valid,
   output logic                            redirect,
   output logic                            ras_miss,
   output logic [$clog2(RAS_DEPTH+1)-1:0]  ras_count
);

   localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);

   pc_cause_e         cause;
   logic [ADDR_W-1:0] next_addr;
   logic [ADDR_W-1:0] ras_top;
   logic              ras_empty;
   logic              ras_push;
   logic              ras_pop;
   logic              miss_next;

   return_addr_stack #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (ins_address + STEP_A),
      .top       (ras_top),
      .count     (ras_count),
      .empty     (ras_empty)
   );

   // Fixed priority trap > branch > return > stall > sequential; only the
   // winning source may touch the stack, so push and pop never coincide.
   always_comb begin
      cause     = SEQ;
      next_addr = ins_address + STEP_A;
      ras_push  = 1'b0;
      ras_pop   = 1'b0;
      miss_next = 1'b0;
      if (trap_en) begin
         cause = TRAP;
      end else if (branch_en) begin
         cause = BRANCH;
      end else if (ret_en) begin
         cause = RET;
      end else if (stall) begin
         cause = HOLD;
      end
      case (cause)
         TRAP: next_addr = ADDR_W'(align_addr(64'(trap_vector), STEP));
         BRANCH: begin
            next_addr = ADDR_W'(align_addr(64'(branch_target), STEP));
            ras_push  = call_en;
         end
         RET: begin
            if (ras_empty) begin
               next_addr = ADDR_W'(align_addr(64'(branch_target), STEP));
               miss_next = 1'b1;
            end else begin
               next_addr = ras_top;
               ras_pop   = 1'b1;
            end
         end
         HOLD:    next_addr = ins_address;
         default: next_addr = ins_address + STEP_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ins_address <= RESET_VEC;
         ins_valid   <= 1'b0;
         redirect    <= 1'b0;
         ras_miss    <= 1'b0;
      end else begin
         ins_address <= next_addr;
         ins_valid   <= 1'b1;
         redirect    <= (cause == TRAP) || (cause == BRANCH) || (cause == RET);
         ras_miss    <= miss_next;
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit (RESET_VEC=0x100, STEP=4, RAS_DEPTH=4).
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        reset, stall, trap_en, branch_en, call_en, ret_en;
   logic [31:0] trap_vector, branch_target;
   logic [31:0] ins_address;
   logic        ins_valid, redirect, ras_miss;
   logic [2:0]  ras_count;

   int checks   = 0;
   int failures = 0;

   fetch_pc_unit #(
      .ADDR_W    (32),
      .STEP      (4),
      .RESET_VEC (32'h100),
      .RAS_DEPTH (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .trap_en       (trap_en),
      .trap_vector   (trap_vector),
      .branch_en     (branch_en),
      .call_en       (call_en),
      .branch_target (branch_target),
      .ret_en        (ret_en),
      .ins_address   (ins_address),
      .ins_valid     (ins_valid),
      .redirect      (redirect),
      .ras_miss      (ras_miss),
      .ras_count     (ras_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 1'b0; stall = 1'b0; trap_en = 1'b0; branch_en = 1'b0;
      call_en = 1'b0; ret_en = 1'b0; trap_vector = '0; branch_target = '0;
   endtask

   // Plain branch (no call) to put the PC somewhere specific.
   task automatic jump(input logic [31:0] addr);
      idle(); branch_en = 1'b1; branch_target = addr;
      tick();
      idle();
   endtask

   task automatic test_reset();
      logic [31:0] exp_seq [3] = '{32'h104, 32'h108, 32'h10C};
      idle(); reset = 1'b1;
      tick(); tick();
      checks++; if (ins_address !== 32'h100) begin failures++; $display("[TB] FAIL reset_addr: got %h expected %h", ins_address, 32'h100); end
      checks++; if (ins_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", ins_valid); end
      checks++; if ({redirect, ras_miss} !== 2'b00) begin failures++; $display("[TB] FAIL reset_pulses: got %b expected 00", {redirect, ras_miss}); end
      checks++; if (ras_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", ras_count); end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (ins_address !== exp_seq[i] || ins_valid !== 1'b1 || redirect !== 1'b0) begin
            failures++; $display("[TB] FAIL seq_%0d: got addr=%h valid=%b redirect=%b expected addr=%h valid=1 redirect=0", i, ins_address, ins_valid, redirect, exp_seq[i]);
         end
      end
   endtask

   task automatic test_stall_branch();
      idle(); stall = 1'b1; branch_en = 1'b1; branch_target = 32'h2000;
      tick();
      checks++; if (ins_address !== 32'h2000 || redirect !== 1'b1) begin failures++; $display("[TB] FAIL stall_branch: got addr=%h redirect=%b expected addr=00002000 redirect=1", ins_address, redirect); end
      idle(); stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (ins_address !== 32'h2000 || redirect !== 1'b0) begin failures++; $display("[TB] FAIL stall_hold_%0d: got addr=%h redirect=%b expected addr=00002000 redirect=0", i, ins_address, redirect); end
      end
      idle();
   endtask

   task automatic test_call_return();
      jump(32'h40);
      branch_en = 1'b1; call_en = 1'b1; branch_target = 32'h800;
      tick();
      checks++; if (ins_address !== 32'h800 || ras_count !== 3'd1 || redirect !== 1'b1) begin failures++; $display("[TB] FAIL call: got addr=%h count=%0d redirect=%b expected addr=00000800 count=1 redirect=1", ins_address, ras_count, redirect); end
      idle(); ret_en = 1'b1; branch_target = 32'h9990;
      tick();
      checks++; if (ins_address !== 32'h44 || ras_count !== 3'd0 || redirect !== 1'b1 || ras_miss !== 1'b0) begin
         failures++; $display("[TB] FAIL return: got addr=%h count=%0d redirect=%b miss=%b expected addr=00000044 count=0 redirect=1 miss=0", ins_address, ras_count, redirect, ras_miss);
      end
      idle();
   endtask

   task automatic test_ras_overflow();
      logic [31:0] exp_ret [5] = '{32'h54, 32'h44, 32'h34, 32'h24, 32'h3000};
      logic [2:0]  exp_cnt [5] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
      for (int i = 1; i <= 5; i++) begin
         jump(32'(i * 16));
         branch_en = 1'b1; call_en = 1'b1; branch_target = 32'h900;
         tick();
      end
      idle();
      checks++; if (ras_count !== 3'd4) begin failures++; $display("[TB] FAIL ras_saturate: got %0d expected 4", ras_count); end
      ret_en = 1'b1; branch_target = 32'h3000;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (ins_address !== exp_ret[i] || ras_count !== exp_cnt[i] || redirect !== 1'b1 || ras_miss !== (i == 4)) begin
            failures++; $display("[TB] FAIL ras_pop_%0d: got addr=%h count=%0d redirect=%b miss=%b expected addr=%h count=%0d redirect=1 miss=%b", i, ins_address, ras_count, redirect, ras_miss, exp_ret[i], exp_cnt[i], i == 4);
         end
      end
      idle();
      tick();
      checks++; if (ras_miss !== 1'b0 || redirect !== 1'b0) begin failures++; $display("[TB] FAIL pulse_clear: got redirect=%b miss=%b expected 0 0", redirect, ras_miss); end
   endtask

   task automatic test_priority();
      jump(32'h200);
      branch_en = 1'b1; call_en = 1'b1; branch_target = 32'h700;
      tick();
      idle(); trap_en = 1'b1; trap_vector = 32'hF00; branch_en = 1'b1; call_en = 1'b1; ret_en = 1'b1; branch_target = 32'h5000;
      tick();
      checks++; if (ins_address !== 32'hF00 || ras_count !== 3'd1 || redirect !== 1'b1) begin failures++; $display("[TB] FAIL trap_priority: got addr=%h count=%0d redirect=%b expected addr=00000f00 count=1 redirect=1", ins_address, ras_count, redirect); end
      idle(); branch_en = 1'b1; branch_target = 32'h1003;
      tick();
      checks++; if (ins_address !== 32'h1000) begin failures++; $display("[TB] FAIL align: got %h expected 00001000", ins_address); end
      idle(); branch_en = 1'b1; ret_en = 1'b1; branch_target = 32'h6000;
      tick();
      checks++; if (ins_address !== 32'h6000 || ras_count !== 3'd1) begin failures++; $display("[TB] FAIL branch_over_ret: got addr=%h count=%0d expected addr=00006000 count=1", ins_address, ras_count); end
      idle(); ret_en = 1'b1;
      tick();
      checks++; if (ins_address !== 32'h204 || ras_count !== 3'd0) begin failures++; $display("[TB] FAIL ret_after_trap: got addr=%h count=%0d expected addr=00000204 count=0", ins_address, ras_count); end
      idle(); call_en = 1'b1; branch_target = 32'h7000;
      tick();
      checks++; if (ins_address !== 32'h208 || ras_count !== 3'd0 || redirect !== 1'b0) begin failures++; $display("[TB] FAIL call_alone: got addr=%h count=%0d redirect=%b expected addr=00000208 count=0 redirect=0", ins_address, ras_count, redirect); end
      idle();
   endtask

   task automatic test_wrap_and_reset();
      jump(32'hFFFF_FFFC);
      checks++; if (ins_address !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_start: got %h expected fffffffc", ins_address); end
      tick();
      checks++; if (ins_address !== 32'h0 || redirect !== 1'b0) begin failures++; $display("[TB] FAIL wrap: got addr=%h redirect=%b expected addr=00000000 redirect=0", ins_address, redirect); end
      branch_en = 1'b1; call_en = 1'b1; branch_target = 32'h800;
      tick(); tick();
      idle(); reset = 1'b1;
      tick();
      checks++; if (ras_count !== 3'd0 || ins_address !== 32'h100 || ins_valid !== 1'b0 || redirect !== 1'b0) begin
         failures++; $display("[TB] FAIL mid_reset: got addr=%h count=%0d valid=%b redirect=%b expected addr=00000100 count=0 valid=0 redirect=0", ins_address, ras_count, ins_valid, redirect);
      end
      idle(); ret_en = 1'b1; branch_target = 32'h1234;
      tick();
      checks++; if (ins_address !== 32'h1234 || ras_miss !== 1'b1 || ras_count !== 3'd0 || ins_valid !== 1'b1) begin
         failures++; $display("[TB] FAIL post_reset_ret: got addr=%h miss=%b count=%0d valid=%b expected addr=00001234 miss=1 count=0 valid=1", ins_address, ras_miss, ras_count, ins_valid);
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_stall_branch();
      test_call_return();
      test_ras_overflow();
      test_priority();
      test_wrap_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
